game_sequencer: RTL and testbench



---
 rtl/game_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_game_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game controller for the asteroid-avoider: IDLE/PLAY/HIT/OVER sequencing, key-to-move pulses,
// tick pacing, collision, score and lives. Define AUTO_REPEAT_EN to add held-key auto-repeat moves.
module game_sequencer #(
   parameter int TICK_DIV     = 25000,
   parameter int HIT_TICKS    = 8,
   parameter int LIVES        = 3,
   parameter int REPEAT_TICKS = 4,
   parameter int SCORE_W      = 10
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                KEY_L,
   input  logic                KEY_R,
   input  logic                KEY_START,
   input  logic [15:0][15:0]   ShipPixels,
   input  logic [15:0][15:0]   RockPixels,
   output logic                SHIP_L,
   output logic                SHIP_R,
   output logic                SHIP_RST,
   output logic                FIELD_STEP,
   output logic                FIELD_CLR,
   output logic [1:0]          STATE,
   output logic [SCORE_W-1:0]  SCORE,
   output logic [2:0]          LIVES_LEFT,
   output logic                GAME_OVER
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_HIT  = 2'd2;
   localparam logic [1:0] S_OVER = 2'd3;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(HIT_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HIT_LAST  = HW'(HIT_TICKS - 1);

   logic                r_armed;
   logic                r_key_l, r_key_r, r_key_s;
   logic                r_prev_l, r_prev_r, r_prev_s;
   logic                r_coll;
   logic [1:0]          r_state;
   logic [TW-1:0]       r_tick_cnt;
   logic [HW-1:0]       r_hit_cnt;
   logic [SCORE_W-1:0]  r_score;
   logic [2:0]          r_lives;
   logic                r_ship_l, r_ship_r, r_ship_rst, r_field_step, r_game_over;

   logic                w_rise_l, w_rise_r, w_rise_s, w_tick, w_rpt_fire;
   logic [1:0]          w_state_nxt;
   logic [TW-1:0]       w_tick_nxt;
   logic [HW-1:0]       w_hit_nxt;
   logic [SCORE_W-1:0]  w_score_nxt;
   logic [2:0]          w_lives_nxt;
   logic                w_ship_l_nxt, w_ship_r_nxt, w_rst_nxt, w_step_nxt;

   assign w_rise_l = r_key_l & ~r_prev_l;
   assign w_rise_r = r_key_r & ~r_prev_r;
   assign w_rise_s = r_key_s & ~r_prev_s;
   assign w_tick   = (r_tick_cnt == TICK_LAST);

`ifdef AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_TICKS + 1);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);

   logic [RW-1:0] r_rpt_cnt;
   logic          w_rpt_run;

   // Counts ticks only while exactly one direction key is held during uninterrupted play.
   assign w_rpt_run  = (r_state == S_PLAY) & (r_key_l ^ r_key_r) & ~r_coll;
   assign w_rpt_fire = w_rpt_run & w_tick & (r_rpt_cnt == RPT_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rpt_cnt <= '0;
      end else if (!w_rpt_run || w_rpt_fire) begin
         r_rpt_cnt <= '0;
      end else if (w_tick) begin
         r_rpt_cnt <= r_rpt_cnt + 1'b1;
      end
   end
`else
   assign w_rpt_fire = 1'b0;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_tick_nxt   = w_tick ? '0 : r_tick_cnt + 1'b1;
      w_hit_nxt    = r_hit_cnt;
      w_score_nxt  = r_score;
      w_lives_nxt  = r_lives;
      w_ship_l_nxt = 1'b0;
      w_ship_r_nxt = 1'b0;
      w_rst_nxt    = 1'b0;
      w_step_nxt   = 1'b0;
      case (r_state)
         S_PLAY: begin
            if (r_coll) begin
               w_lives_nxt = r_lives - 3'd1;
               w_tick_nxt  = '0;
               w_hit_nxt   = '0;
               w_state_nxt = S_HIT;
            end else begin
               if (w_tick) begin
                  w_step_nxt = 1'b1;
                  if (r_score != {SCORE_W{1'b1}}) w_score_nxt = r_score + 1'b1;
               end
               w_ship_l_nxt = (w_rise_l & ~w_rise_r) | (w_rpt_fire & r_key_l);
               w_ship_r_nxt = (w_rise_r & ~w_rise_l) | (w_rpt_fire & r_key_r);
            end
         end
         S_HIT: begin
            if (w_tick) begin
               if (r_hit_cnt == HIT_LAST) begin
                  w_hit_nxt = '0;
                  if (r_lives == 3'd0) begin
                     w_state_nxt = S_OVER;
                  end else begin
                     w_rst_nxt   = 1'b1;
                     w_tick_nxt  = '0;
                     w_state_nxt = S_PLAY;
                  end
               end else begin
                  w_hit_nxt = r_hit_cnt + 1'b1;
               end
            end
         end
         default: begin
            // IDLE and OVER share the start sequence; the counter rests at zero meanwhile.
            w_tick_nxt = '0;
            if (w_rise_s) begin
               w_rst_nxt   = 1'b1;
               w_score_nxt = '0;
               w_lives_nxt = 3'(LIVES);
               w_state_nxt = S_PLAY;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_armed      <= 1'b0;
         r_key_l      <= 1'b0;
         r_key_r      <= 1'b0;
         r_key_s      <= 1'b0;
         r_prev_l     <= 1'b0;
         r_prev_r     <= 1'b0;
         r_prev_s     <= 1'b0;
         r_coll       <= 1'b0;
         r_state      <= S_IDLE;
         r_tick_cnt   <= '0;
         r_hit_cnt    <= '0;
         r_score      <= '0;
         r_lives      <= 3'd0;
         r_ship_l     <= 1'b0;
         r_ship_r     <= 1'b0;
         r_ship_rst   <= 1'b0;
         r_field_step <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         // First edge after reset seeds the previous-key stage so keys held through reset do not rise.
         r_armed      <= 1'b1;
         r_key_l      <= KEY_L;
         r_key_r      <= KEY_R;
         r_key_s      <= KEY_START;
         r_prev_l     <= r_armed ? r_key_l : KEY_L;
         r_prev_r     <= r_armed ? r_key_r : KEY_R;
         r_prev_s     <= r_armed ? r_key_s : KEY_START;
         r_coll       <= |(ShipPixels & RockPixels);
         r_state      <= w_state_nxt;
         r_tick_cnt   <= w_tick_nxt;
         r_hit_cnt    <= w_hit_nxt;
         r_score      <= w_score_nxt;
         r_lives      <= w_lives_nxt;
         r_ship_l     <= w_ship_l_nxt;
         r_ship_r     <= w_ship_r_nxt;
         r_ship_rst   <= w_rst_nxt;
         r_field_step <= w_step_nxt;
         r_game_over  <= (w_state_nxt == S_OVER);
      end
   end

   assign SHIP_L     = r_ship_l;
   assign SHIP_R     = r_ship_r;
   assign SHIP_RST   = r_ship_rst;
   assign FIELD_CLR  = r_ship_rst;
   assign FIELD_STEP = r_field_step;
   assign STATE      = r_state;
   assign SCORE      = r_score;
   assign LIVES_LEFT = r_lives;
   assign GAME_OVER  = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=4, HIT_TICKS=2, LIVES=3, REPEAT_TICKS=2.
module tb_game_sequencer;

   logic                CLK = 1'b0;
   logic                RST_N;
   logic                KEY_L, KEY_R, KEY_START;
   logic [15:0][15:0]   ShipPixels, RockPixels;
   logic                SHIP_L, SHIP_R, SHIP_RST, FIELD_STEP, FIELD_CLR, GAME_OVER;
   logic [1:0]          STATE;
   logic [9:0]          SCORE;
   logic [2:0]          LIVES_LEFT;

   int n_checks = 0;
   int n_err    = 0;
   int pulses;
   int exp_rpt;

   always #5 CLK = ~CLK;

   game_sequencer #(
      .TICK_DIV(4), .HIT_TICKS(2), .LIVES(3), .REPEAT_TICKS(2), .SCORE_W(10)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .KEY_L(KEY_L), .KEY_R(KEY_R), .KEY_START(KEY_START),
      .ShipPixels(ShipPixels), .RockPixels(RockPixels),
      .SHIP_L(SHIP_L), .SHIP_R(SHIP_R), .SHIP_RST(SHIP_RST), .FIELD_STEP(FIELD_STEP),
      .FIELD_CLR(FIELD_CLR), .STATE(STATE), .SCORE(SCORE), .LIVES_LEFT(LIVES_LEFT),
      .GAME_OVER(GAME_OVER)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic overlap(input logic on);
      ShipPixels       = '0;
      RockPixels       = '0;
      ShipPixels[5][7] = on;
      RockPixels[5][7] = on;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST_N = 1'b0; KEY_L = 1'b0; KEY_R = 1'b0; KEY_START = 1'b0;
      overlap(1'b0);
      #23;
      chk("rst_state", STATE, 0);
      chk("rst_lives", LIVES_LEFT, 0);
      chk("rst_score", SCORE, 0);
      chk("rst_pulses", {SHIP_L, SHIP_R, SHIP_RST, FIELD_CLR, FIELD_STEP, GAME_OVER}, 0);
      #4 RST_N = 1'b1;
      tick(3);

      // start: KEY_START held 3 cycles gives one restart pulse
      KEY_START = 1'b1;
      tick(1);
      chk("start_latency_state", STATE, 0);
      chk("start_latency_rst", SHIP_RST, 0);
      tick(1);
      chk("start_ship_rst", SHIP_RST, 1);
      chk("start_field_clr", FIELD_CLR, 1);
      chk("start_state", STATE, 1);
      chk("start_lives", LIVES_LEFT, 3);
      chk("start_score", SCORE, 0);
      tick(1);
      chk("start_rst_single", SHIP_RST, 0);
      KEY_START = 1'b0;
      tick(3);
      chk("first_step", FIELD_STEP, 1);
      chk("first_step_score", SCORE, 1);
      tick(1);
      chk("step_single", FIELD_STEP, 0);
      tick(15);
      chk("score_after_20", SCORE, 5);
      chk("step_at_20", FIELD_STEP, 1);

      // moves: left rise, right rise, then simultaneous rise
      KEY_L = 1'b1;
      tick(2);
      chk("move_l", {SHIP_L, SHIP_R}, 2'b10);
      tick(1);
      chk("move_l_single", SHIP_L, 0);
      KEY_R = 1'b1;
      tick(2);
      chk("move_r", {SHIP_L, SHIP_R}, 2'b01);
      tick(1);
      chk("move_r_single", SHIP_R, 0);
      KEY_L = 1'b0; KEY_R = 1'b0;
      tick(2);
      KEY_L = 1'b1; KEY_R = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         pulses += int'(SHIP_L) + int'(SHIP_R);
      end
      chk("both_rise_no_move", pulses, 0);
      chk("score_after_32", SCORE, 8);
      KEY_L = 1'b0; KEY_R = 1'b0;

      // collision landing on the tick edge
      tick(2);
      overlap(1'b1);
      tick(1);
      overlap(1'b0);
      tick(1);
      chk("hit_state", STATE, 2);
      chk("hit_lives", LIVES_LEFT, 2);
      chk("hit_no_step", FIELD_STEP, 0);
      chk("hit_score_hold", SCORE, 8);
      tick(4);
      chk("hit_tick_suppressed", FIELD_STEP, 0);
      tick(3);
      chk("hit_still", STATE, 2);
      chk("hit_no_rst_yet", SHIP_RST, 0);
      tick(1);
      chk("hit_exit_rst", {SHIP_RST, FIELD_CLR}, 2'b11);
      chk("hit_exit_state", STATE, 1);

      // second and third collisions end the game
      tick(1);
      overlap(1'b1);
      tick(1);
      overlap(1'b0);
      tick(1);
      chk("hit2_lives", LIVES_LEFT, 1);
      tick(8);
      chk("hit2_back_to_play", STATE, 1);
      tick(1);
      overlap(1'b1);
      tick(1);
      overlap(1'b0);
      tick(1);
      chk("hit3_lives", LIVES_LEFT, 0);
      chk("hit3_state", STATE, 2);
      tick(7);
      chk("hit3_still", STATE, 2);
      tick(1);
      chk("over_state", STATE, 3);
      chk("over_flag", GAME_OVER, 1);
      chk("over_no_rst", SHIP_RST, 0);
      chk("over_score", SCORE, 8);
      tick(10);
      chk("over_score_frozen", SCORE, 8);
      chk("over_state_hold", STATE, 3);

      // restart from OVER
      KEY_START = 1'b1;
      tick(2);
      chk("restart_state", STATE, 1);
      chk("restart_score", SCORE, 0);
      chk("restart_lives", LIVES_LEFT, 3);
      chk("restart_flag", GAME_OVER, 0);
      chk("restart_rst", SHIP_RST, 1);
      KEY_START = 1'b0;

      // KEY_R held 20 cycles
      KEY_R  = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 22; i++) begin
         tick(1);
         pulses += int'(SHIP_R);
         if (i == 20) KEY_R = 1'b0;
      end
`ifdef AUTO_REPEAT_EN
      exp_rpt = 3;
`else
      exp_rpt = 1;
`endif
      chk("hold_r_pulses", pulses, exp_rpt);
      chk("hold_score", SCORE, 5);

      // asynchronous reset during HIT
      overlap(1'b1);
      tick(1);
      overlap(1'b0);
      tick(1);
      chk("pre_reset_hit", STATE, 2);
      tick(2);
      #2 RST_N = 1'b0;
      KEY_START = 1'b1;
      #1;
      chk("async_rst_state", STATE, 0);
      chk("async_rst_lives", LIVES_LEFT, 0);
      chk("async_rst_score", SCORE, 0);
      chk("async_rst_outs", {SHIP_L, SHIP_R, SHIP_RST, FIELD_CLR, FIELD_STEP, GAME_OVER}, 0);
      #20 RST_N = 1'b1;
      tick(4);
      chk("held_start_no_rise", STATE, 0);
      chk("held_start_no_rst", SHIP_RST, 0);
      KEY_START = 1'b0;
      tick(2);
      KEY_START = 1'b1;
      tick(2);
      chk("post_reset_start", STATE, 1);
      KEY_START = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
